// File: rtl/io_arbiter_if.sv
// Requester and external-bus signal bundle for io_arbiter.
// slave: the arbiter's view; master: the requester/bus-model view.
interface io_arbiter_if #(
    parameter int N  = 2,
    parameter int DW = 16,
    parameter int AW = 20
);
    logic [N-1:0]     req;
    logic [N-1:0]     ack;
    logic [N-1:0]     rw;
    logic [N-1:0]     pio_sel;
    logic [N*DW-1:0]  dtw;
    logic [N*AW-1:0]  adr;
    logic [DW-1:0]    dtr;
    logic             busy;
    logic [DW-1:0]    din;
    logic [DW-1:0]    dout;
    logic [AW-DW-1:0] adr_hi;
    logic             ale_n;
    logic             oe;
    logic             we;
    logic             pio;
    logic             isout;

    modport slave (
        input  req, rw, pio_sel, dtw, adr, din,
        output ack, dtr, busy, dout, adr_hi, ale_n, oe, we, pio, isout
    );

    modport master (
        output req, rw, pio_sel, dtw, adr, din,
        input  ack, dtr, busy, dout, adr_hi, ale_n, oe, we, pio, isout
    );
endinterface

// File: rtl/io_arbiter.sv
// N-channel arbiter onto a multiplexed address/data IO bus (IDLE/ADDR/DATA/ACK).
// Define IO_ARBITER_RR_EN for round-robin arbitration; default is fixed priority (highest index wins).
module io_arbiter #(
    parameter int N    = 2,
    parameter int DW   = 16,
    parameter int AW   = 20,
    parameter int WAIT = 0
) (
    input  logic         clk,
    input  logic         rst,
    io_arbiter_if.slave  bus
);
    localparam int GW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, ADDR, DATA, ACK} state_t;

    state_t           state_q, state_d;
    logic [3:0]       wcnt_q, wcnt_d;
    logic [N-1:0]     ack_q, ack_d;
    logic             busy_q, busy_d;
    logic             oe_q, oe_d;
    logic             we_q, we_d;
    logic             ale_n_q, ale_n_d;
    logic             isout_q, isout_d;
    logic             pio_q, pio_d;
    logic [DW-1:0]    dout_q, dout_d;
    logic [DW-1:0]    dtr_q, dtr_d;
    logic [AW-DW-1:0] adr_hi_q, adr_hi_d;

    // Transaction context latched at grant
    logic [GW-1:0]    gnt_q, gnt_d;
    logic             rw_q, rw_d;
    logic [DW-1:0]    wdat_q, wdat_d;

    logic [GW-1:0]    sel;
    logic             grant;
    logic [AW-1:0]    sel_adr;
    logic [DW-1:0]    sel_dtw;
    logic             sel_rw;
    logic             sel_pio;

    assign grant = (state_q == IDLE) && (|bus.req);

    generate
        if (N == 1) begin : g_single
            assign sel = '0;
        end else begin : g_multi
`ifdef IO_ARBITER_RR_EN
            logic [GW-1:0] rr_ptr_q, rr_ptr_d;

            // Pick the requester closest above the last grant, wrapping around
            always_comb begin
                int best;
                int dist;
                sel  = rr_ptr_q;
                best = N;
                dist = 0;
                for (int i = 0; i < N; i++) begin
                    dist = (i + N - 1 - int'(rr_ptr_q)) % N;
                    if (bus.req[i] && (dist < best)) begin
                        best = dist;
                        sel  = GW'(i);
                    end
                end
            end

            assign rr_ptr_d = grant ? sel : rr_ptr_q;

            always_ff @(posedge clk) begin
                if (rst) rr_ptr_q <= '0;
                else     rr_ptr_q <= rr_ptr_d;
            end
`else
            always_comb begin
                sel = '0;
                for (int i = 0; i < N; i++) begin
                    if (bus.req[i]) sel = GW'(i);
                end
            end
`endif
        end
    endgenerate

    always_comb begin
        sel_adr = '0;
        sel_dtw = '0;
        sel_rw  = 1'b0;
        sel_pio = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (sel == GW'(i)) begin
                sel_adr = bus.adr[i*AW +: AW];
                sel_dtw = bus.dtw[i*DW +: DW];
                sel_rw  = bus.rw[i];
                sel_pio = bus.pio_sel[i];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        wcnt_d   = wcnt_q;
        ack_d    = ack_q;
        busy_d   = busy_q;
        oe_d     = oe_q;
        we_d     = we_q;
        ale_n_d  = ale_n_q;
        isout_d  = isout_q;
        pio_d    = pio_q;
        dout_d   = dout_q;
        dtr_d    = dtr_q;
        adr_hi_d = adr_hi_q;
        gnt_d    = gnt_q;
        rw_d     = rw_q;
        wdat_d   = wdat_q;
        case (state_q)
            IDLE: begin
                if (grant) begin
                    gnt_d                = sel;
                    rw_d                 = sel_rw;
                    wdat_d               = sel_dtw;
                    {adr_hi_d, dout_d}   = sel_adr;
                    ale_n_d              = 1'b0;
                    isout_d              = 1'b1;
                    busy_d               = 1'b1;
                    pio_d                = sel_pio;
                    state_d              = ADDR;
                end
            end
            ADDR: begin
                ale_n_d = 1'b1;
                wcnt_d  = 4'(WAIT);
                if (rw_q) begin
                    dout_d = wdat_q;
                    we_d   = 1'b1;
                end else begin
                    isout_d = 1'b0;
                    oe_d    = 1'b1;
                end
                state_d = DATA;
            end
            DATA: begin
                if (wcnt_q == 4'd0) begin
                    if (!rw_q) dtr_d = bus.din;
                    oe_d    = 1'b0;
                    we_d    = 1'b0;
                    isout_d = 1'b0;
                    for (int i = 0; i < N; i++) ack_d[i] = (gnt_q == GW'(i));
                    state_d = ACK;
                end else begin
                    wcnt_d = wcnt_q - 4'd1;
                end
            end
            ACK: begin
                ack_d   = '0;
                busy_d  = 1'b0;
                pio_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            wcnt_q   <= '0;
            ack_q    <= '0;
            busy_q   <= 1'b0;
            oe_q     <= 1'b0;
            we_q     <= 1'b0;
            ale_n_q  <= 1'b1;
            isout_q  <= 1'b0;
            pio_q    <= 1'b0;
            dout_q   <= '0;
            dtr_q    <= '0;
            adr_hi_q <= '0;
        end else begin
            state_q  <= state_d;
            wcnt_q   <= wcnt_d;
            ack_q    <= ack_d;
            busy_q   <= busy_d;
            oe_q     <= oe_d;
            we_q     <= we_d;
            ale_n_q  <= ale_n_d;
            isout_q  <= isout_d;
            pio_q    <= pio_d;
            dout_q   <= dout_d;
            dtr_q    <= dtr_d;
            adr_hi_q <= adr_hi_d;
        end
    end

    // Context registers are only meaningful while a transaction is in flight
    always_ff @(posedge clk) begin
        gnt_q  <= gnt_d;
        rw_q   <= rw_d;
        wdat_q <= wdat_d;
    end

    assign bus.ack    = ack_q;
    assign bus.busy   = busy_q;
    assign bus.oe     = oe_q;
    assign bus.we     = we_q;
    assign bus.ale_n  = ale_n_q;
    assign bus.isout  = isout_q;
    assign bus.pio    = pio_q;
    assign bus.dout   = dout_q;
    assign bus.dtr    = dtr_q;
    assign bus.adr_hi = adr_hi_q;
endmodule

// File: tb/tb_io_arbiter.sv
// Self-checking bench for io_arbiter: directed scenarios plus randomized traffic
// compared cycle by cycle against a transaction-timeline reference model.
module tb_io_arbiter;
    localparam int N    = 2;
    localparam int DW   = 16;
    localparam int AW   = 20;
    localparam int WAIT = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    io_arbiter_if #(.N(N), .DW(DW), .AW(AW)) bus ();

    io_arbiter #(.N(N), .DW(DW), .AW(AW), .WAIT(WAIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [N-1:0]     ack;
        logic             busy;
        logic             oe;
        logic             we;
        logic             ale_n;
        logic             isout;
        logic             pio;
        logic [AW-DW-1:0] adr_hi;
        logic [DW-1:0]    dout;
        logic [DW-1:0]    dtr;
    } obs_t;

    int   n_tests = 0;
    int   n_fail  = 0;
    obs_t rst_exp;

    // Reference model: position within the current transaction's timeline
    obs_t          m_exp;
    int            m_t    = -1;
    int            m_g    = 0;
    int            m_last = 0;
    logic          m_rw;
    logic          m_pio;
    logic [AW-1:0] m_adr;
    logic [DW-1:0] m_dtw;

    function automatic obs_t observe();
        obs_t o;
        o.ack    = bus.ack;
        o.busy   = bus.busy;
        o.oe     = bus.oe;
        o.we     = bus.we;
        o.ale_n  = bus.ale_n;
        o.isout  = bus.isout;
        o.pio    = bus.pio;
        o.adr_hi = bus.adr_hi;
        o.dout   = bus.dout;
        o.dtr    = bus.dtr;
        return o;
    endfunction

    function automatic int arbitrate(input logic [N-1:0] r);
        int g;
        int c;
        g = -1;
`ifdef IO_ARBITER_RR_EN
        for (int k = 1; k <= N; k++) begin
            c = (m_last + k) % N;
            if (g < 0 && r[c]) g = c;
        end
`else
        c = 0;
        for (int i = 0; i < N; i++) if (r[i]) g = i;
`endif
        return g;
    endfunction

    // Expected outputs after the coming rising edge, given inputs now on the bus
    task automatic model_edge();
        if (rst) begin
            m_t    = -1;
            m_last = 0;
            m_exp  = rst_exp;
        end else if (m_t < 0) begin
            if (|bus.req) begin
                m_g          = arbitrate(bus.req);
                m_last       = m_g;
                m_rw         = bus.rw[m_g];
                m_pio        = bus.pio_sel[m_g];
                m_adr        = bus.adr[m_g*AW +: AW];
                m_dtw        = bus.dtw[m_g*DW +: DW];
                m_exp.adr_hi = m_adr[AW-1:DW];
                m_exp.dout   = m_adr[DW-1:0];
                m_exp.ale_n  = 1'b0;
                m_exp.isout  = 1'b1;
                m_exp.busy   = 1'b1;
                m_exp.pio    = m_pio;
                m_t          = 0;
            end
        end else begin
            m_t++;
            if (m_t <= WAIT + 1) begin
                m_exp.ale_n = 1'b1;
                m_exp.oe    = !m_rw;
                m_exp.we    = m_rw;
                m_exp.isout = m_rw;
                if (m_rw) m_exp.dout = m_dtw;
            end else if (m_t == WAIT + 2) begin
                m_exp.ack      = '0;
                m_exp.ack[m_g] = 1'b1;
                m_exp.oe       = 1'b0;
                m_exp.we       = 1'b0;
                m_exp.isout    = 1'b0;
                if (!m_rw) m_exp.dtr = bus.din;
            end else begin
                m_exp.ack  = '0;
                m_exp.busy = 1'b0;
                m_exp.pio  = 1'b0;
                m_t        = -1;
            end
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble_ctx();
        bus.rw      = N'($urandom);
        bus.pio_sel = N'($urandom);
        bus.dtw     = (N*DW)'({$urandom, $urandom});
        bus.adr     = (N*AW)'({$urandom, $urandom});
    endtask

    task automatic test_reset();
        obs_t obs;
        rst     = 1'b1;
        bus.req = '0;
        bus.rw  = '0;
        bus.pio_sel = '0;
        bus.dtw = '0;
        bus.adr = '0;
        bus.din = '0;
        tick();
        tick();
        obs = observe();
        n_tests++;
        if (obs !== rst_exp) begin
            n_fail++;
            $display("FAIL reset_state: got %h expected %h", obs, rst_exp);
        end
        rst = 1'b0;
        tick();
        obs = observe();
        n_tests++;
        if (obs !== rst_exp) begin
            n_fail++;
            $display("FAIL reset_idle_hold: got %h expected %h", obs, rst_exp);
        end
    endtask

    task automatic test_read();
        obs_t obs;
        int   ack_k = -1;
        int   ale_cnt = 0;
        bus.rw      = 2'b00;
        bus.pio_sel = 2'b00;
        bus.adr[0 +: AW] = 20'h3A5C7;
        bus.din     = 16'hBEEF;
        bus.req     = 2'b01;
        for (int k = 0; k <= WAIT + 3; k++) begin
            tick();
            obs = observe();
            n_tests++;
            if (obs !== m_exp) begin
                n_fail++;
                $display("FAIL read_cycle%0d: got %h expected %h", k, obs, m_exp);
            end
            if (k == 0) begin
                n_tests++;
                if ({obs.adr_hi, obs.dout, obs.ale_n} !== {4'h3, 16'hA5C7, 1'b0}) begin
                    n_fail++;
                    $display("FAIL read_addr_phase: got %h/%h ale_n=%b expected 3/a5c7 ale_n=0",
                             obs.adr_hi, obs.dout, obs.ale_n);
                end
                scramble_ctx();
            end
            if (obs.ale_n === 1'b0) ale_cnt++;
            if (obs.ack !== '0) begin
                ack_k = k;
                n_tests++;
                if (obs.ack !== 2'b01) begin
                    n_fail++;
                    $display("FAIL read_ack_chan: got %b expected 01", obs.ack);
                end
                bus.req = '0;
            end
        end
        n_tests++;
        if (ack_k !== WAIT + 2) begin
            n_fail++;
            $display("FAIL read_ack_latency: got cycle %0d expected %0d", ack_k, WAIT + 2);
        end
        n_tests++;
        if ((obs.dtr !== 16'hBEEF) || (ale_cnt !== 1)) begin
            n_fail++;
            $display("FAIL read_dtr: got dtr=%h ale_cycles=%0d expected dtr=beef ale_cycles=1",
                     obs.dtr, ale_cnt);
        end
    endtask

    task automatic test_write();
        obs_t obs;
        int   ack_k = -1;
        int   we_cnt = 0;
        bus.rw       = 2'b10;
        bus.pio_sel  = 2'b00;
        bus.dtw[DW +: DW] = 16'h1234;
        bus.adr[AW +: AW] = 20'hF00D5;
        bus.din      = DW'($urandom);
        bus.req      = 2'b10;
        for (int k = 0; k <= WAIT + 3; k++) begin
            tick();
            obs = observe();
            n_tests++;
            if (obs !== m_exp) begin
                n_fail++;
                $display("FAIL write_cycle%0d: got %h expected %h", k, obs, m_exp);
            end
            if (k == 0) scramble_ctx();
            bus.din = DW'($urandom);
            if (obs.we === 1'b1) begin
                we_cnt++;
                n_tests++;
                if (obs.dout !== 16'h1234) begin
                    n_fail++;
                    $display("FAIL write_dout: got %h expected 1234", obs.dout);
                end
            end
            if (obs.ack !== '0) begin
                ack_k = k;
                n_tests++;
                if (obs.ack !== 2'b10) begin
                    n_fail++;
                    $display("FAIL write_ack_chan: got %b expected 10", obs.ack);
                end
                bus.req = '0;
            end
        end
        n_tests++;
        if ((we_cnt !== WAIT + 1) || (ack_k !== WAIT + 2) || (obs.dtr !== 16'hBEEF)) begin
            n_fail++;
            $display("FAIL write_timing: got we=%0d ack_at=%0d dtr=%h expected we=%0d ack_at=%0d dtr=beef",
                     we_cnt, ack_k, obs.dtr, WAIT + 1, WAIT + 2);
        end
    endtask

    task automatic test_back_to_back();
        obs_t obs;
        int   grants[4];
        int   exp_g[4];
        int   ack_at[4];
        int   n_ack = 0;
`ifdef IO_ARBITER_RR_EN
        exp_g = '{1, 0, 1, 0};
`else
        exp_g = '{1, 1, 1, 1};
`endif
        rst = 1'b1;
        tick();
        obs = observe();
        n_tests++;
        if (obs !== rst_exp) begin
            n_fail++;
            $display("FAIL b2b_reset: got %h expected %h", obs, rst_exp);
        end
        rst     = 1'b0;
        bus.rw  = 2'b00;
        bus.req = 2'b11;
        for (int c = 1; c <= 4 * (WAIT + 4) + 2; c++) begin
            tick();
            obs = observe();
            n_tests++;
            if (obs !== m_exp) begin
                n_fail++;
                $display("FAIL b2b_cycle%0d: got %h expected %h", c, obs, m_exp);
            end
            if (obs.ack !== '0 && n_ack < 4) begin
                grants[n_ack] = (obs.ack === 2'b10) ? 1 : 0;
                ack_at[n_ack] = c;
                n_ack++;
                if (n_ack == 4) bus.req = '0;
            end
        end
        n_tests++;
        if (n_ack !== 4) begin
            n_fail++;
            $display("FAIL b2b_ack_count: got %0d expected 4", n_ack);
        end else begin
            for (int j = 0; j < 4; j++) begin
                n_tests++;
                if (grants[j] !== exp_g[j]) begin
                    n_fail++;
                    $display("FAIL b2b_grant%0d: got %0d expected %0d", j, grants[j], exp_g[j]);
                end
                if (j > 0) begin
                    n_tests++;
                    if (ack_at[j] - ack_at[j-1] !== WAIT + 4) begin
                        n_fail++;
                        $display("FAIL b2b_spacing%0d: got %0d expected %0d",
                                 j, ack_at[j] - ack_at[j-1], WAIT + 4);
                    end
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        obs_t obs;
        bit   seen = 1'b0;
        bus.rw      = 2'b00;
        bus.pio_sel = 2'b01;
        bus.din     = 16'h5A5A;
        bus.req     = 2'b01;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        obs = observe();
        n_tests++;
        if (obs !== rst_exp) begin
            n_fail++;
            $display("FAIL midrst_state: got %h expected %h", obs, rst_exp);
        end
        rst = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            tick();
            obs = observe();
            n_tests++;
            if (obs !== m_exp) begin
                n_fail++;
                $display("FAIL midrst_cycle%0d: got %h expected %h", c, obs, m_exp);
            end
            if (obs.ack === 2'b01) begin
                seen    = 1'b1;
                bus.req = '0;
            end
        end
        n_tests++;
        if (!seen) begin
            n_fail++;
            $display("FAIL midrst_regrant: got no ack[0] within 20 cycles, required one");
        end
        tick();
        tick();
    endtask

    task automatic test_pio();
        obs_t obs;
        bus.rw      = 2'b00;
        bus.pio_sel = 2'b01;
        bus.req     = 2'b01;
        for (int k = 0; k <= WAIT + 4; k++) begin
            tick();
            obs = observe();
            if (obs.ack !== '0) bus.req = '0;
            n_tests++;
            if (obs.pio !== ((k <= WAIT + 2) ? 1'b1 : 1'b0)) begin
                n_fail++;
                $display("FAIL pio_cycle%0d: got %b expected %b", k, obs.pio, (k <= WAIT + 2));
            end
            n_tests++;
            if ((obs.oe & obs.we) !== 1'b0 || obs !== m_exp) begin
                n_fail++;
                $display("FAIL pio_state%0d: got %h expected %h", k, obs, m_exp);
            end
        end
    endtask

    task automatic test_random();
        obs_t obs;
        for (int c = 0; c < 400; c++) begin
            scramble_ctx();
            bus.din = DW'($urandom);
            tick();
            obs = observe();
            n_tests++;
            if (obs !== m_exp) begin
                n_fail++;
                $display("FAIL rand_cycle%0d: got %h expected %h", c, obs, m_exp);
            end
            n_tests++;
            if (((obs.oe & obs.we) !== 1'b0) || ($countones(obs.ack) > 1)) begin
                n_fail++;
                $display("FAIL rand_invariant%0d: got oe=%b we=%b ack=%b expected exclusive strobes and one-hot ack",
                         c, obs.oe, obs.we, obs.ack);
            end
            for (int i = 0; i < N; i++) begin
                if (bus.req[i] && m_exp.ack[i]) begin
                    if ($urandom_range(0, 1) == 1) bus.req[i] = 1'b0;
                end else if (!bus.req[i]) begin
                    if ($urandom_range(0, 9) < 3) bus.req[i] = 1'b1;
                end
            end
        end
        bus.req = '0;
        for (int c = 0; c < WAIT + 5; c++) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        rst_exp       = '0;
        rst_exp.ale_n = 1'b1;
        m_exp         = rst_exp;
        test_reset();
        test_read();
        test_write();
        test_back_to_back();
        test_reset_mid();
        test_pio();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
